pc_sequencer: RTL and testbench

- Control FSM that drives the fetch stage's PC-source select, PC enable, flush and return-address pop strobes.
- Sequences three cases:
  - one-cycle redirects for unconditional jump and call, decoded in D;
  - two-word return-address pop for RET/RTI;
  - interrupt entry, with a pipeline-drain counter, to the ISR vector.
- Sits between decode, execute and writeback hazard signals and the fetch stage's control inputs.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Purpose  : Hazard/decode inputs and fetch-control outputs of pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic       intr;
    logic       jump_D;
    logic       ret_D;
    logic       branch_E;
    logic       stall_D;
    logic       pop_valid;
    logic       pc_enb;
    logic       flush;
    logic [1:0] jump_sel;
    logic [1:0] pop_l_h;
    logic       int_ack;
    logic       busy;
    logic       seq_err;

    modport master (
        output intr, jump_D, ret_D, branch_E, stall_D, pop_valid,
        input  pc_enb, flush, jump_sel, pop_l_h, int_ack, busy, seq_err
    );

    modport slave (
        input  intr, jump_D, ret_D, branch_E, stall_D, pop_valid,
        output pc_enb, flush, jump_sel, pop_l_h, int_ack, busy, seq_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-control FSM for jump/call, RET/RTI pops and interrupt entry.
//            Optional return-pop timeout enabled by macro PC_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 4,
    parameter int RET_TIMEOUT  = 12
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  ctl
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RET_H     = 3'd1,
        ST_RET_L     = 3'd2,
        ST_RET_GO    = 3'd3,
        ST_INT_DRAIN = 3'd4,
        ST_INT_GO    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_int_pend;
    logic             w_pc_enb;
    logic             w_flush;
    logic [1:0]       w_jump_sel;
    logic [1:0]       w_pop_l_h;
    logic             w_int_ack;

`ifdef PC_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(RET_TIMEOUT - 1);

    logic [CNT_W-1:0] r_tmo;
    logic             r_seq_err;
    logic             w_in_ret;
    logic             w_tmo_hit;
    logic             w_tmo_fire;

    assign w_in_ret   = (r_state == ST_RET_H) || (r_state == ST_RET_L);
    assign w_tmo_hit  = (r_tmo == c_TMO_LAST);
    assign w_tmo_fire = w_in_ret && (w_state_nxt == ST_INT_GO);

    // Counter restarts on every pop; it stays at 0 outside the RET wait states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo     <= '0;
            r_seq_err <= 1'b0;
        end else begin
            if (w_in_ret && !ctl.pop_valid && (w_state_nxt == r_state))
                r_tmo <= r_tmo + 1'b1;
            else
                r_tmo <= '0;
            if (w_tmo_fire)
                r_seq_err <= 1'b1;
        end
    end

    assign ctl.seq_err = r_seq_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^RET_TIMEOUT;
    assign ctl.seq_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_int_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == ST_INT_GO)
                r_int_pend <= 1'b0;
            else if (ctl.intr)
                r_int_pend <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_enb    = 1'b0;
        w_flush     = 1'b1;
        w_jump_sel  = 2'b00;
        w_pop_l_h   = 2'b00;
        w_int_ack   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A taken branch in E makes anything decoded in D wrong-path.
                if (ctl.branch_E) begin
                    w_pc_enb = 1'b1;
                    w_flush  = 1'b0;
                end else if (r_int_pend || ctl.intr) begin
                    w_state_nxt = ST_INT_DRAIN;
                    w_cnt_nxt   = c_DRAIN_LOAD;
                end else if (ctl.ret_D) begin
                    w_state_nxt = ST_RET_H;
                end else if (ctl.jump_D) begin
                    w_pc_enb   = 1'b1;
                    w_jump_sel = 2'b01;
                end else if (ctl.stall_D) begin
                    w_flush = 1'b0;
                end else begin
                    w_pc_enb = 1'b1;
                    w_flush  = 1'b0;
                end
            end
            ST_RET_H: begin
                if (ctl.pop_valid) begin
                    w_pop_l_h   = 2'b10;
                    w_state_nxt = ST_RET_L;
                end else if (ctl.branch_E) begin
                    w_state_nxt = ST_IDLE;
                end
`ifdef PC_SEQ_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_nxt = ST_INT_GO;
                end
`endif
            end
            ST_RET_L: begin
                if (ctl.pop_valid) begin
                    w_pop_l_h   = 2'b11;
                    w_state_nxt = ST_RET_GO;
                end
`ifdef PC_SEQ_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_nxt = ST_INT_GO;
                end
`endif
            end
            ST_RET_GO: begin
                w_pc_enb    = 1'b1;
                w_jump_sel  = 2'b11;
                w_state_nxt = ST_IDLE;
            end
            ST_INT_DRAIN: begin
                if (r_cnt == '0)
                    w_state_nxt = ST_INT_GO;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            ST_INT_GO: begin
                w_pc_enb    = 1'b1;
                w_jump_sel  = 2'b10;
                w_int_ack   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ctl.pc_enb   = rst ? 1'b0  : w_pc_enb;
    assign ctl.flush    = rst ? 1'b1  : w_flush;
    assign ctl.jump_sel = rst ? 2'b00 : w_jump_sel;
    assign ctl.pop_l_h  = rst ? 2'b00 : w_pop_l_h;
    assign ctl.int_ack  = rst ? 1'b0  : w_int_ack;
    assign ctl.busy     = rst ? 1'b0  : (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed scoreboard bench for pc_sequencer (DRAIN_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    // Input vector: {intr, jump_D, ret_D, branch_E, stall_D, pop_valid}
    localparam logic [5:0] I_NONE  = 6'b000000;
    localparam logic [5:0] I_INTR  = 6'b100000;
    localparam logic [5:0] I_JUMP  = 6'b010000;
    localparam logic [5:0] I_RET   = 6'b001000;
    localparam logic [5:0] I_BR    = 6'b000100;
    localparam logic [5:0] I_STALL = 6'b000010;
    localparam logic [5:0] I_POP   = 6'b000001;

    // Output vector: {pc_enb, flush, jump_sel[1:0], pop_l_h[1:0], int_ack, busy, seq_err}
    localparam logic [8:0] O_RST   = 9'b0_1_00_00_0_0_0;
    localparam logic [8:0] O_HOLD  = 9'b0_1_00_00_0_0_0;
    localparam logic [8:0] O_RUN   = 9'b1_0_00_00_0_0_0;
    localparam logic [8:0] O_JUMP  = 9'b1_1_01_00_0_0_0;
    localparam logic [8:0] O_STALL = 9'b0_0_00_00_0_0_0;
    localparam logic [8:0] O_WAIT  = 9'b0_1_00_00_0_1_0;
    localparam logic [8:0] O_POPH  = 9'b0_1_00_10_0_1_0;
    localparam logic [8:0] O_POPL  = 9'b0_1_00_11_0_1_0;
    localparam logic [8:0] O_RETGO = 9'b1_1_11_00_0_1_0;
    localparam logic [8:0] O_INTGO = 9'b1_1_10_00_1_1_0;

    typedef struct {
        logic [8:0] exp;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    pc_sequencer_if bus();

    pc_sequencer #(
        .DRAIN_CYCLES (3),
        .CNT_W        (4),
        .RET_TIMEOUT  (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic [5:0] in, input logic [8:0] exp, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        {bus.intr, bus.jump_D, bus.ret_D, bus.branch_E, bus.stall_D, bus.pop_valid} = in;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: outputs are combinational, so each cycle is checked on the falling edge.
    initial begin
        exp_t       e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {bus.pc_enb, bus.flush, bus.jump_sel, bus.pop_l_h,
                       bus.int_ack, bus.busy, bus.seq_err};
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got {pc_enb,flush,jsel,pop,ack,busy,err}=%b expected %b",
                             e.name, got, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        {bus.intr, bus.jump_D, bus.ret_D, bus.branch_E, bus.stall_D, bus.pop_valid} = I_NONE;
        repeat (2) @(posedge clk);

        // Reset and release
        cyc(1, I_NONE, O_RST, "rst_a");
        cyc(1, I_JUMP, O_RST, "rst_b");
        cyc(0, I_NONE, O_RUN, "release");

        // Jump, stall, branch priority over D-stage decodes
        cyc(0, I_JUMP, O_JUMP, "jump");
        cyc(0, I_NONE, O_RUN,  "jump_next");
        cyc(0, I_STALL, O_STALL, "stall");
        cyc(0, I_BR | I_JUMP | I_RET, O_RUN, "br_prio");
        cyc(0, I_NONE, O_RUN, "br_after");
        cyc(0, I_POP,  O_RUN, "pop_in_idle");

        // RET with pops at +3 and +5; stall and branch ignored while busy
        cyc(0, I_RET,   O_HOLD,  "ret+0");
        cyc(0, I_NONE,  O_WAIT,  "ret+1");
        cyc(0, I_STALL, O_WAIT,  "ret+2");
        cyc(0, I_POP,   O_POPH,  "ret+3");
        cyc(0, I_BR,    O_WAIT,  "ret+4");
        cyc(0, I_POP,   O_POPL,  "ret+5");
        cyc(0, I_NONE,  O_RETGO, "ret+6");
        cyc(0, I_NONE,  O_RUN,   "ret+7");

        // RET aborted by a branch before any pop
        cyc(0, I_RET,  O_HOLD, "abort+0");
        cyc(0, I_NONE, O_WAIT, "abort+1");
        cyc(0, I_BR,   O_WAIT, "abort+2");
        cyc(0, I_NONE, O_RUN,  "abort+3");
        cyc(0, I_NONE, O_RUN,  "abort+4");

        // Interrupt pulse: 3 drain cycles then INT_GO; pop ignored while draining
        cyc(0, I_INTR, O_HOLD,  "int+0");
        cyc(0, I_NONE, O_WAIT,  "int+1");
        cyc(0, I_POP,  O_WAIT,  "int+2");
        cyc(0, I_NONE, O_WAIT,  "int+3");
        cyc(0, I_NONE, O_INTGO, "int+4");
        cyc(0, I_NONE, O_RUN,   "int+5");

        // Interrupt during RET_L is deferred until after RET_GO
        cyc(0, I_RET,  O_HOLD,  "dfr+0");
        cyc(0, I_POP,  O_POPH,  "dfr+1");
        cyc(0, I_INTR, O_WAIT,  "dfr+2");
        cyc(0, I_POP,  O_POPL,  "dfr+3");
        cyc(0, I_NONE, O_RETGO, "dfr+4");
        cyc(0, I_NONE, O_HOLD,  "dfr+5");
        cyc(0, I_NONE, O_WAIT,  "dfr+6");
        cyc(0, I_NONE, O_WAIT,  "dfr+7");
        cyc(0, I_NONE, O_WAIT,  "dfr+8");
        cyc(0, I_NONE, O_INTGO, "dfr+9");
        cyc(0, I_NONE, O_RUN,   "dfr+10");

        // intr held through INT_GO but dropped after: no second entry
        cyc(0, I_INTR, O_HOLD,  "hold+0");
        cyc(0, I_INTR, O_WAIT,  "hold+1");
        cyc(0, I_INTR, O_WAIT,  "hold+2");
        cyc(0, I_INTR, O_WAIT,  "hold+3");
        cyc(0, I_INTR, O_INTGO, "hold+4");
        cyc(0, I_NONE, O_RUN,   "hold+5");

        // intr still high the cycle after INT_GO: re-entry
        cyc(0, I_INTR, O_HOLD,  "re+0");
        cyc(0, I_NONE, O_WAIT,  "re+1");
        cyc(0, I_NONE, O_WAIT,  "re+2");
        cyc(0, I_NONE, O_WAIT,  "re+3");
        cyc(0, I_INTR, O_INTGO, "re+4");
        cyc(0, I_INTR, O_HOLD,  "re+5");
        cyc(0, I_NONE, O_WAIT,  "re+6");
        cyc(0, I_NONE, O_WAIT,  "re+7");
        cyc(0, I_NONE, O_WAIT,  "re+8");
        cyc(0, I_NONE, O_INTGO, "re+9");
        cyc(0, I_NONE, O_RUN,   "re+10");

`ifdef PC_SEQ_TIMEOUT_EN
        // RET with no pop times out after 12 waiting cycles; seq_err is sticky
        cyc(0, I_RET, O_HOLD, "tmo+0");
        for (int i = 1; i <= 12; i++)
            cyc(0, I_NONE, O_WAIT, $sformatf("tmo+%0d", i));
        cyc(0, I_NONE, O_INTGO | 9'b1, "tmo_fire");
        cyc(0, I_NONE, O_RUN | 9'b1,   "tmo_sticky");
        cyc(1, I_NONE, O_RST | 9'b1,   "tmo_rst");
        cyc(0, I_NONE, O_RUN,          "tmo_cleared");
`endif

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
